// File: rtl/seg_out_ctrl.sv
// seg_out_ctrl: queues 32-bit words and writes each one to the display data register once the
// display ready flag reads 1, then waits for the flag to clear. Option macro: SEG_OUT_TIMEOUT_EN.
module seg_out_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [7:0]  RDY_ADDR = 8'h08,
  parameter logic [7:0]  SEG_ADDR = 8'h0C
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic [7:0]             io_addr,
  output logic [31:0]            io_dout,
  output logic                   io_we,
  output logic                   io_rd,
  input  logic [31:0]            io_din,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            sent_cnt,
  output logic                   err_to
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StPoll, StWrite, StWaitClr} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [15:0]   sent_q;
  logic          rdy_flag, full, push, pop, drop, timeout;
  logic          unused_din;

  // Only bit 0 of the ready register carries the flag.
  assign rdy_flag   = io_din[0];
  assign unused_din = ^io_din[31:1];

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == StWrite) | drop;

`ifdef SEG_OUT_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q;
  logic          to_hit;

  assign timeout = (wait_cnt_q == CW'(TIMEOUT - 1));
  // A ready flag seen on the last allowed cycle still wins over the timeout.
  assign to_hit  = timeout & (((state_q == StPoll) & ~rdy_flag) |
                              ((state_q == StWaitClr) & rdy_flag));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == StPoll) || (state_q == StWaitClr)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign err_to = err_q;
`else
  assign timeout = 1'b0;
  assign err_to  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) state_d = StPoll;
      end
      StPoll: begin
        if (rdy_flag) begin
          state_d = StWrite;
        end else if (timeout) begin
          state_d = StIdle;
          drop    = 1'b1;
        end
      end
      StWrite: begin
        state_d = StWaitClr;
      end
      StWaitClr: begin
        if (!rdy_flag || timeout) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus outputs decoded from registered state only
  always_comb begin
    io_addr = 8'h00;
    io_dout = 32'h0;
    io_we   = 1'b0;
    io_rd   = 1'b0;
    unique case (state_q)
      StPoll, StWaitClr: begin
        io_addr = RDY_ADDR;
        io_rd   = 1'b1;
      end
      StWrite: begin
        io_addr = SEG_ADDR;
        io_dout = mem_q[rd_ptr_q];
        io_we   = 1'b1;
      end
      default: ;
    endcase
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sent_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: ;
      endcase
      if (state_q == StWrite) sent_q <= sent_q + 16'd1;
    end
  end

  assign level    = level_q;
  assign sent_cnt = sent_q;
  assign busy     = (state_q != StIdle) | (level_q != '0);

endmodule

// File: tb/tb_seg_out_ctrl.sv
// tb_seg_out_ctrl: vector table, directed corner sequences and a randomized run checked
// against a queue model of the output FIFO and the ready-flag write protocol.
module tb_seg_out_ctrl;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [7:0]  RDY     = 8'h08;
  localparam logic [7:0]  SEG     = 8'h0C;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din = 32'h0;
  logic        busy;
  logic [2:0]  level;
  logic [15:0] sent_cnt;
  logic        err_to;

  seg_out_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .RDY_ADDR(RDY),
    .SEG_ADDR(SEG)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we),
    .io_rd   (io_rd),
    .io_din  (io_din),
    .busy    (busy),
    .level   (level),
    .sent_cnt(sent_cnt),
    .err_to  (err_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        din;
    logic        rdy;
    logic        we;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic [2:0]  lvl;
    logic        bsy;
    logic [15:0] sent;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    io_din   = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Services the ready handshake and compares each write against expq in order.
  task automatic drain(input string name, input int n);
    int got = 0;
    int zl  = 1;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      if (io_we) begin
        chk({name, " word"}, io_dout, expq.pop_front());
        got++;
        zl = 2;
      end
      io_din = (zl == 0) ? 32'd1 : 32'd0;
      if (zl > 0) zl--;
      tick();
      cyc++;
    end
    chk({name, " write count"}, 32'(got), 32'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nwe;
    int found;
    int sent_m;
    int nwr;
    bit poll_ok;
    bit armed;
    bit acc;
    logic [31:0] mq[$];

    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 3'd1, 1'b1, 16'd0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 32'h0, 3'd1, 1'b1, 16'd0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0C, 32'hDEADBEEF, 3'd1, 1'b1, 16'd0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 32'h0, 3'd0, 1'b1, 16'd1};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 32'h0, 3'd0, 1'b1, 16'd1};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 16'd1};

    // Reset state
    do_reset();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset level", 32'(level), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset io_we", 32'(io_we), 32'd0);
    chk("reset io_rd", 32'(io_rd), 32'd0);
    chk("reset io_addr", 32'(io_addr), 32'd0);
    chk("reset io_dout", io_dout, 32'd0);
    chk("reset sent_cnt", 32'(sent_cnt), 32'd0);
    chk("reset err_to", 32'(err_to), 32'd0);

    // Basic write: io_we on the 3rd cycle after the push edge
    for (int i = 0; i < 6; i++) begin
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      io_din   = {31'd0, vecs[i].din};
      tick();
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d io_we", i), 32'(io_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d io_rd", i), 32'(io_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d io_addr", i), 32'(io_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d io_dout", i), io_dout, vecs[i].dout);
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("vec%0d sent_cnt", i), 32'(sent_cnt), 32'(vecs[i].sent));
    end

    // Full FIFO, then a push held across the WRITE cycle while full
    do_reset();
    io_din = 32'd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 3) chk("full in_ready after 4", 32'(in_ready), 32'd0);
    end
    chk("full level", 32'(level), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    io_din = 32'd1;
    tick();
    chk("full write we", 32'(io_we), 32'd1);
    chk("full write head", io_dout, 32'hA000_0000);
    chk("full write in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full after pop level", 32'(level), 32'd3);
    chk("full after pop in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("full 5th stored level", 32'(level), 32'd4);
    in_valid = 1'b0;
    expq.delete();
    for (int i = 1; i < 5; i++) expq.push_back(32'hA000_0000 + 32'(i));
    drain("full drain", 4);

    // Push accepted on the WRITE cycle while not full: level unchanged
    do_reset();
    io_din = 32'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    io_din   = 32'd1;
    tick();
    chk("pp write we", 32'(io_we), 32'd1);
    chk("pp write head", io_dout, 32'hC000_0000);
    in_valid = 1'b1;
    in_data  = 32'hC000_0003;
    tick();
    in_valid = 1'b0;
    chk("pp level", 32'(level), 32'd3);
    chk("pp sent_cnt", 32'(sent_cnt), 32'd1);
    expq.delete();
    for (int i = 1; i < 4; i++) expq.push_back(32'hC000_0000 + 32'(i));
    drain("pp drain", 3);

    // Ready handshake: flag held high allows exactly one write
    do_reset();
    io_din   = 32'd1;
    in_valid = 1'b1;
    in_data  = 32'hB000_0000;
    tick();
    in_data  = 32'hB000_0001;
    tick();
    in_valid = 1'b0;
    nwe = 0;
    for (int i = 0; i < 12; i++) begin
      if (io_we) begin
        nwe++;
        chk("hs first word", io_dout, 32'hB000_0000);
      end
      tick();
    end
    chk("hs single write", 32'(nwe), 32'd1);
    chk("hs wait_clr rd", 32'(io_rd), 32'd1);
    chk("hs wait_clr addr", 32'(io_addr), 32'(RDY));
    chk("hs level", 32'(level), 32'd1);
    io_din = 32'd0;
    tick();
    io_din = 32'd1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (io_we) begin
        found = 1;
        chk("hs second word", io_dout, 32'hB000_0001);
      end else begin
        tick();
      end
    end
    chk("hs second write seen", 32'(found), 32'd1);

    // Reset asserted during WRITE
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'hD000_0000;
    tick();
    in_valid = 1'b0;
    expq.delete();
    expq.push_back(32'hD000_0000);
    drain("rst first", 1);
    in_valid = 1'b1;
    in_data  = 32'hD000_0001;
    io_din   = 32'd0;
    tick();
    in_valid = 1'b0;
    io_din   = 32'd1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (io_we) found = 1;
      else tick();
    end
    chk("rst write reached", 32'(found), 32'd1);
    chk("rst sent before", 32'(sent_cnt), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst io_we", 32'(io_we), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst sent_cnt", 32'(sent_cnt), 32'd0);
    chk("rst io_addr", 32'(io_addr), 32'd0);
    chk("rst io_dout", io_dout, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'hE000_0000;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst in_ready after release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("rst first push level", 32'(level), 32'd1);

    // Randomized run against the queue model
    do_reset();
    mq.delete();
    sent_m  = 0;
    nwr     = 0;
    poll_ok = 1'b0;
    armed   = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rand level", 32'(level), 32'(mq.size()));
      chk("rand in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("rand sent_cnt", 32'(sent_cnt), 32'(sent_m[15:0]));
      chk("rand we_rd exclusive", 32'(io_we & io_rd), 32'd0);
      if (mq.size() != 0) chk("rand busy", 32'(busy), 32'd1);
      if (!io_we) chk("rand idle dout", io_dout, 32'd0);
      if (io_we) begin
        chk("rand write addr", 32'(io_addr), 32'(SEG));
        chk("rand write data", io_dout, (mq.size() != 0) ? mq[0] : 32'hxxxx_xxxx);
        chk("rand write after ready", 32'(poll_ok), 32'd1);
        chk("rand write after clear", 32'(armed), 32'd1);
      end
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = $urandom();
      io_din   = {$urandom(), 1'b0} | {31'd0, $urandom_range(0, 3) != 0};
      poll_ok  = io_rd && (io_addr == RDY) && io_din[0];
      if (io_we) armed = 1'b0;
      else if (io_rd && !io_din[0]) armed = 1'b1;
      acc = in_valid && (mq.size() < DEPTH);
      if (io_we && mq.size() != 0) begin
        void'(mq.pop_front());
        sent_m++;
        nwr++;
      end
      if (acc) mq.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    chk("rand writes occurred", 32'(nwr > 20), 32'd1);

`ifdef SEG_OUT_TIMEOUT_EN
    // Timeout: word dropped after TIMEOUT POLL cycles, never written
    do_reset();
    io_din   = 32'd0;
    in_valid = 1'b1;
    in_data  = 32'hF000_0000;
    tick();
    in_valid = 1'b0;
    nwe = 0;
    for (int i = 0; i < 20; i++) begin
      if (io_we) nwe++;
      tick();
    end
    chk("to err_to", 32'(err_to), 32'd1);
    chk("to level", 32'(level), 32'd0);
    chk("to no write", 32'(nwe), 32'd0);
    chk("to sent_cnt", 32'(sent_cnt), 32'd0);
`else
    chk("err_to tied low", 32'(err_to), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
